// File: rtl/leaf_port_arbiter_if.sv
// leaf_port_arbiter_if: requester streams plus the single registered output lane
interface leaf_port_arbiter_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2
);
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din;
  logic [NUM_REQ-1:0]              req_vld;
  logic [NUM_REQ-1:0]              req_ack;
  logic [PAYLOAD_BITS-1:0]         dout;
  logic                            dout_vld;
  logic                            dout_ack;
  logic [REQ_BITS-1:0]             grant_id;
  logic                            busy;
  modport master (
    input  req_din, req_vld, dout_ack,
    output req_ack, dout, dout_vld, grant_id, busy
  );
  modport slave (
    output req_din, req_vld, dout_ack,
    input  req_ack, dout, dout_vld, grant_id, busy
  );
endinterface

// File: rtl/leaf_port_arbiter.sv
// leaf_port_arbiter: round-robin burst arbiter sharing one registered leaf output lane
module leaf_port_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2,
  parameter int MAX_BURST    = 16,
  parameter int BURST_BITS   = 4
) (
  input  logic               clk_user,
  input  logic               reset_n,
  leaf_port_arbiter_if.master bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                  state, state_nx;
  logic [REQ_BITS-1:0]     rr_ptr, grant_id, sel, idx, g_next;
  logic [BURST_BITS-1:0]   burst_cnt;
  logic [PAYLOAD_BITS-1:0] dout, din_sel;
  logic                    dout_vld, sel_vld, or_ld, g_vld, accept, burst_end;
  // lowest offset from rr_ptr wins, so scan offsets downward and let the last hit stick
  always_comb begin
    sel     = rr_ptr;
    sel_vld = 1'b0;
    idx     = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = REQ_BITS'((int'(rr_ptr) + i) % NUM_REQ);
      if (bus.req_vld[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end
  always_comb begin
    g_next    = (grant_id == REQ_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    or_ld     = !dout_vld || bus.dout_ack;
    g_vld     = bus.req_vld[grant_id];
    accept    = (state == GRANT) && g_vld && or_ld;
    burst_end = burst_cnt == BURST_BITS'(MAX_BURST - 1);
    din_sel   = bus.req_din[int'(grant_id)*PAYLOAD_BITS +: PAYLOAD_BITS];
    state_nx  = (state == IDLE) ? (sel_vld ? GRANT : IDLE)
              : (!g_vld || (accept && burst_end)) ? IDLE : GRANT;
  end
  always_ff @(posedge clk_user or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
    end else begin
      if (state == IDLE && sel_vld) begin
        grant_id  <= sel;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
      end
      if (state == GRANT && state_nx == IDLE) rr_ptr <= g_next;
      if (accept) begin
        dout     <= din_sel;
        dout_vld <= 1'b1;
      end else if (bus.dout_ack) begin
        dout_vld <= 1'b0;
      end
    end
  end
  assign bus.req_ack  = (state == GRANT && or_ld) ? NUM_REQ'(1) << grant_id : '0;
  assign bus.dout     = dout;
  assign bus.dout_vld = dout_vld;
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state == GRANT) || dout_vld;
endmodule

// File: tb/tb_leaf_port_arbiter.sv
// tb_leaf_port_arbiter: directed steps with an in-order output scoreboard
module tb_leaf_port_arbiter;
  localparam int P = 32, N = 4, RB = 2, MB = 16, BB = 4;
  logic clk_user = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_user = ~clk_user;
  leaf_port_arbiter_if #(.PAYLOAD_BITS(P), .NUM_REQ(N), .REQ_BITS(RB)) bus();
  leaf_port_arbiter #(.PAYLOAD_BITS(P), .NUM_REQ(N), .REQ_BITS(RB), .MAX_BURST(MB), .BURST_BITS(BB))
    dut (.clk_user(clk_user), .reset_n(reset_n), .bus(bus));
  int          total = 0, bad = 0;
  int          acc_id;
  int          cnt [N];
  logic [31:0] base [N];
  logic [31:0] exp_q [$];
  logic [31:0] w;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_din();
    for (int i = 0; i < N; i++) bus.req_din[i*P +: P] = base[i] + cnt[i];
  endtask
  // sample mid-cycle, then advance one edge and record the accepted word
  task automatic step();
    @(negedge clk_user);
    acc_id = -1;
    for (int i = 0; i < N; i++) if (bus.req_vld[i] && bus.req_ack[i]) acc_id = i;
    check("ack_onehot0", 32'($onehot0(bus.req_ack)), 1);
    if (bus.dout_vld && bus.dout_ack) begin
      if (exp_q.size() == 0) check("dout_extra", bus.dout, 32'hdead_beef);
      else check("dout_order", bus.dout, exp_q.pop_front());
    end
    @(posedge clk_user);
    #1;
    if (acc_id >= 0) begin
      exp_q.push_back(base[acc_id] + cnt[acc_id]);
      cnt[acc_id]++;
    end
    drive_din();
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      base[i] = 32'(i) << 24;
      cnt[i]  = 0;
    end
    base[2] = 32'h100;
    bus.req_vld  = '0;
    bus.dout_ack = 1'b1;
    drive_din();
    #1;
    check("rst_dout", bus.dout, 0);
    check("rst_dout_vld", 32'(bus.dout_vld), 0);
    check("rst_grant", 32'(bus.grant_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.req_ack), 0);
    @(posedge clk_user);
    @(posedge clk_user);
    #1 reset_n = 1'b1;
    // single stream on req 2
    bus.req_vld = 4'b0100;
    step();
    check("t1_bubble", acc_id, -1);
    check("t1_grant", 32'(bus.grant_id), 2);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_acc", acc_id, 2);
      check("t1_dout", bus.dout, 32'h100 + 32'(k));
      check("t1_dout_vld", 32'(bus.dout_vld), 1);
    end
    bus.req_vld = '0;
    step();
    check("t1_idle_busy", 32'(bus.busy), 0);
    // wrap: rr_ptr=3, only req 1 valid; then rr_ptr=2 must pick 3 over 0/1
    bus.req_vld = 4'b0010;
    step();
    check("wrap_grant1", 32'(bus.grant_id), 1);
    bus.req_vld = '0;
    step();
    bus.req_vld = 4'b1011;
    step();
    check("wrap_grant3", 32'(bus.grant_id), 3);
    bus.req_vld = '0;
    step();
    // burst limit on req 0
    bus.req_vld = 4'b0001;
    step();
    check("t2_bubble0", acc_id, -1);
    check("t2_grant", 32'(bus.grant_id), 0);
    for (int k = 0; k < MB; k++) begin
      step();
      check("t2_acc", acc_id, 0);
    end
    step();
    check("t2_bubble", acc_id, -1);
    step();
    check("t2_regrant", acc_id, 0);
    bus.req_vld = '0;
    step();
    bus.req_vld = 4'b1000;
    step();
    bus.req_vld = '0;
    step();
    // fairness: all requesters valid, expect 0,1,2,3,0 with full bursts
    bus.req_vld = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      step();
      check("t3_bubble", acc_id, -1);
      check("t3_grant", 32'(bus.grant_id), 32'(r % N));
      for (int k = 0; k < MB; k++) begin
        step();
        check("t3_acc", acc_id, r % N);
      end
    end
    bus.req_vld = '0;
    step();
    // back-pressure on req 1
    bus.req_vld = 4'b0010;
    step();
    check("t4_grant", 32'(bus.grant_id), 1);
    bus.dout_ack = 1'b0;
    step();
    check("t4_first_acc", acc_id, 1);
    w = base[1] + 32'(cnt[1]) - 32'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_stall_acc", acc_id, -1);
      check("t4_dout_hold", bus.dout, w);
      check("t4_dout_vld", 32'(bus.dout_vld), 1);
    end
    bus.dout_ack = 1'b1;
    step();
    check("t4_resume_acc", acc_id, 1);
    bus.req_vld = '0;
    step();
    step();
    // async reset mid-burst to req 3
    bus.req_vld = 4'b1000;
    step();
    check("t5_grant", 32'(bus.grant_id), 3);
    step();
    check("t5_acc", acc_id, 3);
    step();
    #2 reset_n = 1'b0;
    bus.req_vld = 4'b1010;
    #1;
    check("t5_rst_dout", bus.dout, 0);
    check("t5_rst_vld", 32'(bus.dout_vld), 0);
    check("t5_rst_grant", 32'(bus.grant_id), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_ack", 32'(bus.req_ack), 0);
    exp_q.delete();
    @(posedge clk_user);
    @(posedge clk_user);
    #1 reset_n = 1'b1;
    step();
    check("t5_post_grant", 32'(bus.grant_id), 1);
    bus.req_vld = '0;
    step();
    step();
    check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_vld", 32'(bus.dout_vld), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/leaf_port_arbiter.md
# leaf_port_arbiter

Round-robin arbiter that shares one leaf_interface output port among several user-side output streams inside a leaf. It sits between the HLS operator's stream outputs (ap_vld/ap_ack style) and a single `din_leaf_user2interface` lane. It grants one requester at a time for a bounded burst and registers the selected word toward the interface. It also reports the current grantee so packets can be tagged downstream.

## Interface
- PAYLOAD_BITS, 32, width of one stream word
- NUM_REQ, 4, number of requesting streams (≥2)
- REQ_BITS, 2, width of the grantee index; ceil(log2(NUM_REQ))
- MAX_BURST, 16, maximum words accepted per grant (≥1)
- BURST_BITS, 4, width of the burst counter; ceil(log2(MAX_BURST))

Ports:
- clk_user  in  1  user clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- req_din  in  NUM_REQ*PAYLOAD_BITS  requester words; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- req_vld  in  NUM_REQ  per-requester word valid
- req_ack  out  NUM_REQ  per-requester accept; at most one bit high
- dout  out  PAYLOAD_BITS  registered word to the interface
- dout_vld  out  1  dout valid
- dout_ack  in  1  interface accepts dout
- grant_id  out  REQ_BITS  index of the current or last grantee
- busy  out  1  high when state is GRANT or dout_vld is high

## Operation
- A transfer occurs on any clk_user edge where vld and ack are both high. This holds on both the requester side and the output side.
- Output register OR (dout, dout_vld):
  - OR can load when dout_vld==0 or dout_ack==1.
  - On an accepted requester word, OR loads that word and dout_vld is set to 1.
  - When dout_ack==1 and no new word is accepted, dout_vld is cleared to 0.
  - While dout_vld==1 and dout_ack==0, dout holds stable.
- FSM states:
  - IDLE:
    - req_ack=0.
    - If any req_vld bit is high, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
    - Load grant_id with that index, clear burst_cnt, and go to GRANT.
    - If no req_vld bit is high, stay in IDLE.
  - GRANT, with g = grant_id:
    - req_ack[g] = (dout_vld==0 || dout_ack==1); this is combinational. All other req_ack bits are 0.
    - Each accepted word increments burst_cnt.
  - GRANT → IDLE when either of these holds:
    - (a) req_vld[g]==0 in the current cycle, so no word is accepted that cycle.
    - (b) a word is accepted while burst_cnt==MAX_BURST-1.
  - On the GRANT → IDLE transition, rr_ptr becomes (g+1) mod NUM_REQ. The wrap is explicit, so it also holds for non-power-of-two NUM_REQ.
- grant_id holds its value in IDLE.
- Requests from non-granted streams are ignored until the next IDLE arbitration; they are never lost.
- A requester that drops vld mid-burst loses its grant, even if it reasserts vld the next cycle.
- OR drains independently of the FSM; a pending dout never blocks the return to IDLE.

## Timing
- Reset (asynchronous assert, synchronous-release behaviour of downstream logic is not this block's concern). Values while reset_n==0:
  - state = IDLE, rr_ptr = 0, burst_cnt = 0, grant_id = 0
  - dout = 0, dout_vld = 0, req_ack = 0, busy = 0
- Reset mid-burst discards any word in OR; the word is not re-sent.
- Arbitration bubble: req_vld sampled high in IDLE at edge k gives state GRANT after edge k. req_ack can be high in cycle k+1.
- Latency: a word accepted at edge t is on dout with dout_vld=1 after edge t.
- Throughput is one word per cycle while dout_ack is held high. Each grant costs one IDLE cycle.
- The worst-case wait for a continuously requesting stream is (NUM_REQ-1)*(MAX_BURST+1) cycles plus output back-pressure.
- burst_cnt never exceeds MAX_BURST-1; it is cleared on entry to GRANT.

## Test plan
- Single stream: NUM_REQ=4, only req 2 valid with words 0x100..0x104, dout_ack=1.
  - Grant_id=2 one cycle after vld.
  - dout shows 0x100..0x104 on consecutive cycles, each one cycle after its accept.
  - Return to IDLE when req_vld[2] drops; rr_ptr=3.
- Burst limit: MAX_BURST=16, req 0 always valid with an incrementing pattern.
  - Exactly 16 words are accepted, then one IDLE cycle.
  - req 0 is regranted (only requester), and word 17 follows word 16 in order.
- Round-robin fairness: all 4 requesters always valid, dout_ack=1.
  - Grant order is 0,1,2,3,0.
  - Each grant is exactly 16 words; no word is duplicated or dropped (checked by per-stream scoreboard).
- Back-pressure: req 1 granted with dout_ack=0 for 5 cycles.
  - One word is accepted and dout stays stable.
  - req_ack[1] stays 0 until the cycle dout_ack=1, then a new word is accepted in that same cycle.
- Wrap with gaps: rr_ptr=3 and only req 1 valid → grant_id=1, then rr_ptr=2.
- Async reset mid-burst: assert reset_n=0 during a grant to req 3.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the first grant goes to the lowest valid index ≥0.
